// File: rtl/m_alu_seq_core.sv
// m_alu_seq_core: handshaked ALU with iterative shifts and shift-add multiply.
// Result, flags and err are registered and held until writeback consumes them.
module m_alu_seq_core #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags,
  output logic             err
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_ASR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [3:0]       rop;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [SW-1:0]    sa;
  logic             msb_a;
  logic             msb_b;

  logic [WIDTH-1:0] d_res;
  logic [3:0]       d_flg;
  logic             d_c;
  logic             d_v;
  logic             d_err;
  logic             d_busy;
  logic [WIDTH-1:0] d_acc;
  logic [CW-1:0]    d_cnt;

  logic [CW-1:0]    step;
  logic [WIDTH-1:0] b_acc;
  logic [CW-1:0]    b_cnt;

  assign in_ready = rst_n && (state == IDLE);

  assign sum   = {1'b0, a_in} + {1'b0, b_in};
  assign dif   = {1'b0, a_in} - {1'b0, b_in};
  assign sa    = b_in[SW-1:0];
  assign msb_a = a_in[WIDTH-1];
  assign msb_b = b_in[WIDTH-1];

  // single-cycle results and iteration setup for the accept edge
  always_comb begin
    d_res  = '0;
    d_c    = 1'b0;
    d_v    = 1'b0;
    d_err  = 1'b0;
    d_busy = 1'b0;
    d_acc  = a_in;
    d_cnt  = {1'b0, sa};
    unique case (op)
      OP_ADD: begin
        d_res = sum[WIDTH-1:0];
        d_c   = sum[WIDTH];
        d_v   = (msb_a == msb_b) && (sum[WIDTH-1] != msb_a);
      end
      OP_SUB: begin
        d_res = dif[WIDTH-1:0];
        d_c   = ~dif[WIDTH];
        d_v   = (msb_a != msb_b) && (dif[WIDTH-1] != msb_a);
      end
      OP_AND: d_res = a_in & b_in;
      OP_OR:  d_res = a_in | b_in;
      OP_XOR: d_res = a_in ^ b_in;
      OP_SHL, OP_SHR, OP_ASR: begin
        d_res  = a_in;
        d_busy = (sa != '0);
      end
      OP_MUL: begin
        d_busy = 1'b1;
        d_acc  = '0;
        d_cnt  = CW'(WIDTH);
      end
      default: d_err = 1'b1;
    endcase
    d_flg = d_err ? 4'b0001
                  : {d_v, d_c, d_res[WIDTH-1], d_res == '0};
  end

  always_comb begin
    step  = (cnt > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : cnt;
    b_acc = acc;
    b_cnt = cnt - step;
    unique case (rop)
      OP_SHL: b_acc = acc << step;
      OP_SHR: b_acc = acc >> step;
      OP_ASR: b_acc = $signed(acc) >>> step;
      OP_MUL: begin
        b_acc = rb[0] ? acc + ra : acc;
        b_cnt = cnt - CW'(1);
      end
      default: b_acc = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out       <= '0;
      flags     <= '0;
      err       <= 1'b0;
      acc       <= '0;
      ra        <= '0;
      rb        <= '0;
      rop       <= '0;
      cnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            ra  <= a_in;
            rb  <= b_in;
            rop <= op;
            acc <= d_acc;
            cnt <= d_cnt;
            if (d_busy) begin
              state <= BUSY;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              out       <= d_res;
              flags     <= d_flg;
              err       <= d_err;
            end
          end
        end
        BUSY: begin
          acc <= b_acc;
          cnt <= b_cnt;
          if (rop == OP_MUL) begin
            ra <= ra << 1;
            rb <= rb >> 1;
          end
          if (b_cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out       <= b_acc;
            flags     <= {2'b00, b_acc[WIDTH-1], b_acc == '0};
            err       <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_m_alu_seq_core.sv
// tb_m_alu_seq_core: random and directed ops, scoreboard against a
// plain-arithmetic reference model, with randomized writeback back-pressure.
module tb_m_alu_seq_core;
  localparam int W  = 32;
  localparam int S  = 4;
  localparam int W2 = 2 * W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic [3:0]   op = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out;
  logic [3:0]   flags;
  logic         err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hold_req = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;
    logic         er;
    int           lat;
    int           acc_cyc;
    string        nm;
  } exp_t;

  exp_t q[$];

  m_alu_seq_core #(.WIDTH(W), .SHIFT_STEP(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flags(flags), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic [3:0] o);
    exp_t e;
    longint unsigned ua, ub, top;
    longint sa, sb, r, smax, smin;
    logic [W2-1:0] p;
    logic c, v;
    int s;
    ua = a;
    ub = b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    top = 64'd1 << W;
    smax = (64'sd1 <<< (W - 1)) - 1;
    smin = -smax - 1;
    s = int'(ub % W);
    c = 1'b0;
    v = 1'b0;
    e.er = 1'b0;
    e.lat = 1;
    e.res = '0;
    e.flg = '0;
    e.nm = "";
    e.acc_cyc = 0;
    case (o)
      4'd0: begin
        e.res = W'(ua + ub);
        c = (ua + ub) >= top;
        r = sa + sb;
        v = (r > smax) || (r < smin);
      end
      4'd1: begin
        e.res = W'(ua - ub);
        c = ua >= ub;
        r = sa - sb;
        v = (r > smax) || (r < smin);
      end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5, 4'd6, 4'd7: begin
        if (o == 4'd5) e.res = a << s;
        else if (o == 4'd6) e.res = a >> s;
        else e.res = $signed(a) >>> s;
        if (s != 0) e.lat = 1 + (s + S - 1) / S;
      end
      4'd8: begin
        p = W2'(a) * W2'(b);
        e.res = p[W-1:0];
        e.lat = 1 + W;
      end
      default: begin
        e.er = 1'b1;
        e.flg = 4'b0001;
        return e;
      end
    endcase
    e.flg = {v, c, e.res[W-1], e.res == '0};
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] o, input string nm);
    exp_t e;
    int t;
    e = model(a, b, o);
    e.nm = nm;
    @(negedge clk);
    a_in = a;
    b_in = b;
    op = o;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL %s_accept: got in_ready=0 want 1 within 300 cycles", nm);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.acc_cyc = cyc;
    q.push_back(e);
    in_valid = 1'b0;
    a_in = $urandom;
    b_in = $urandom;
    op = 4'($urandom);
  endtask

  // monitor: latency on first out_valid, hold stability, compare on handshake
  logic         seen = 1'b0;
  logic         hs_prev = 1'b0;
  int           hold_cnt = 0;
  logic [W-1:0] h_out;
  logic [3:0]   h_flg;
  logic         h_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
      hs_prev = 1'b0;
      hold_cnt = 0;
      out_ready = 1'b0;
    end else begin
      if (hs_prev) chk("ready_after_hs", in_ready, 1);
      hs_prev = 1'b0;
      if (out_valid) begin
        chk("in_ready_in_done", in_ready, 0);
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: got out=%0h want no output", out);
          out_ready = 1'b1;
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk({q[0].nm, "_lat"}, 64'(cyc - q[0].acc_cyc + 1), 64'(q[0].lat));
            hold_cnt = hold_req;
            hold_req = 0;
            h_out = out;
            h_flg = flags;
            h_err = err;
          end else begin
            chk({q[0].nm, "_hold_out"}, out, h_out);
            chk({q[0].nm, "_hold_flags"}, flags, h_flg);
            chk({q[0].nm, "_hold_err"}, err, h_err);
          end
          if (hold_cnt > 0) begin
            out_ready = 1'b0;
            hold_cnt--;
          end else begin
            out_ready = ($urandom_range(0, 3) != 0);
          end
          if (out_ready) begin
            chk({q[0].nm, "_out"}, out, q[0].res);
            chk({q[0].nm, "_flags"}, flags, q[0].flg);
            chk({q[0].nm, "_err"}, err, q[0].er);
            void'(q.pop_front());
            seen = 1'b0;
            hs_prev = 1'b1;
          end
        end
      end else begin
        out_ready = ($urandom_range(0, 3) == 0);
      end
    end
  end

  task automatic reset_mid_mul();
    issue(32'h0001_0000, 32'h0001_0001, 4'd8, "mul_rst");
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    q.delete();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_flags", flags, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    chk("rst_in_ready_held", in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", in_ready, 1);
  endtask

  initial begin
    logic [3:0] ro;
    int t;
    repeat (3) @(negedge clk);
    chk("init_out_valid", out_valid, 0);
    chk("init_out", out, 0);
    chk("init_flags", flags, 0);
    chk("init_err", err, 0);
    chk("init_in_ready", in_ready, 0);
    rst_n = 1'b1;

    issue(32'hFFFF_FFFF, 32'h1, 4'd0, "add_wrap");
    issue(32'h8000_0000, 32'h1, 4'd1, "sub_ovf");
    issue(32'h1, 32'h2, 4'd1, "sub_borrow");
    issue(32'h7FFF_FFFF, 32'h1, 4'd0, "add_ovf");
    issue(32'h8000_0000, 32'd31, 4'd7, "asr31");
    issue(32'h1234_5678, 32'd0, 4'd5, "shl0");
    issue(32'h8765_4321, 32'd32, 4'd6, "shr_amt_wrap");
    issue(32'hF0F0_1234, 32'd5, 4'd5, "shl5");
    issue(32'h0001_0000, 32'h0001_0001, 4'd8, "mul");
    hold_req = 5;
    issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 4'd4, "bp_xor");
    issue(32'hFF00_FF00, 32'h0FF0_0FF0, 4'd2, "and");
    issue(32'h0, 32'h0, 4'd3, "or_zero");
    reset_mid_mul();
    issue(32'h5, 32'h6, 4'd12, "illegal");

    for (int i = 0; i < 150; i++) begin
      ro = 4'($urandom_range(0, 11));
      if (ro > 4'd8) ro = 4'(9 + $urandom_range(0, 6));
      if (i % 17 == 0) hold_req = $urandom_range(1, 6);
      issue($urandom, $urandom, ro, "rnd");
    end

    t = 0;
    while (q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
